// File: rtl/pll_clk_seq.sv
// rtl/pll_clk_seq.sv - PLL reset pulse, lock qualification and staged clock-enable / domain-reset sequencer
// Optional feature macro: PLL_CLK_SEQ_RELOCK_EN (re-reset the PLL after LOCK_TIMEOUT cycles without lock)
module pll_clk_seq #(
    parameter int NCH          = 7,
    parameter int LOCK_CNT     = 1024,
    parameter int SEQ_GAP      = 16,
    parameter int PLL_RST_CYC  = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic           clkin,
    input  logic           rst_n,
    input  logic           pll_lock,
    output logic           pll_reset,
    output logic [NCH-1:0] enclk,
    output logic [NCH-1:0] dom_rst_n,
    output logic           all_ready,
    output logic [2:0]     state,
    output logic [7:0]     relock_cnt
);

    // One shared counter serves every state, so it is sized for the longest interval any state needs.
    localparam int SEQ_END = NCH * SEQ_GAP;
    localparam int MAX_A   = (LOCK_CNT > PLL_RST_CYC) ? LOCK_CNT : PLL_RST_CYC;
    localparam int MAX_B   = (LOCK_TIMEOUT > SEQ_END) ? LOCK_TIMEOUT : SEQ_END;
    localparam int MAX_V   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_V + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_ENABLE    = 3'd3,
        S_RUN       = 3'd4
    } st_t;

    st_t           st;
    logic          lk_meta;
    logic          lk;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    relock_sat;

    assign state      = st;
    assign cnt_inc    = cnt + CW'(1);
    assign relock_sat = (relock_cnt == 8'hFF) ? 8'hFF : relock_cnt + 8'd1;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_lock;
            lk      <= lk_meta;
        end
    end

    // Sequencer FSM: PLL reset pulse, lock wait, lock qualification, staged enables, run with lock monitoring.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_RESET_PLL;
            pll_reset  <= 1'b1;
            cnt        <= '0;
            enclk      <= '0;
            dom_rst_n  <= '0;
            all_ready  <= 1'b0;
            relock_cnt <= '0;
        end else begin
            case (st)
                S_RESET_PLL: begin
                    if (cnt == CW'(PLL_RST_CYC - 1)) begin
                        st        <= S_WAIT_LOCK;
                        pll_reset <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        st  <= S_STABLE;
                        cnt <= '0;
                    end
`ifdef PLL_CLK_SEQ_RELOCK_EN
                    else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        st         <= S_RESET_PLL;
                        pll_reset  <= 1'b1;
                        cnt        <= '0;
                        relock_cnt <= relock_sat;
                    end else begin
                        cnt <= cnt_inc;
                    end
`else
                    // Without re-lock the PLL is trusted to lock eventually; the counter is left idle.
`endif
                end
                S_STABLE: begin
                    if (!lk) begin
                        st  <= S_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == CW'(LOCK_CNT - 1)) begin
                        // enclk[0] must already be high in the first ENABLE cycle.
                        st    <= S_ENABLE;
                        cnt   <= '0;
                        enclk <= NCH'(1);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_ENABLE, S_RUN: begin
                    if (!lk) begin
                        st         <= S_WAIT_LOCK;
                        cnt        <= '0;
                        enclk      <= '0;
                        dom_rst_n  <= '0;
                        all_ready  <= 1'b0;
                        relock_cnt <= relock_sat;
                    end else if (st == S_ENABLE) begin
                        // cnt holds the cycle index since ENABLE entry; cnt_inc is the index of the next cycle.
                        cnt <= cnt_inc;
                        for (int i = 0; i < NCH; i++) begin
                            if (cnt_inc == CW'(i * SEQ_GAP))
                                enclk[i] <= 1'b1;
                            if (cnt_inc == CW'((i + 1) * SEQ_GAP))
                                dom_rst_n[i] <= 1'b1;
                        end
                        if (cnt_inc == CW'(SEQ_END)) begin
                            st        <= S_RUN;
                            all_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    st        <= S_RESET_PLL;
                    pll_reset <= 1'b1;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_clk_seq.sv
// tb/tb_pll_clk_seq.sv - directed self-checking bench for pll_clk_seq
module tb_pll_clk_seq;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic [2:0] enclk;
    logic [2:0] dom_rst_n;
    logic       all_ready;
    logic [2:0] state;
    logic [7:0] relock_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pll_clk_seq #(
        .NCH          (3),
        .LOCK_CNT     (8),
        .SEQ_GAP      (4),
        .PLL_RST_CYC  (4),
        .LOCK_TIMEOUT (32)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .enclk      (enclk),
        .dom_rst_n  (dom_rst_n),
        .all_ready  (all_ready),
        .state      (state),
        .relock_cnt (relock_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  {29'd0, state},      32'd0);
        chk({tag, "_pllrst"}, {31'd0, pll_reset},  32'd1);
        chk({tag, "_enclk"},  {29'd0, enclk},      32'd0);
        chk({tag, "_domrst"}, {29'd0, dom_rst_n},  32'd0);
        chk({tag, "_ready"},  {31'd0, all_ready},  32'd0);
        chk({tag, "_relock"}, {24'd0, relock_cnt}, 32'd0);
    endtask

    initial begin
        int k;
        int seen;
        int exp_rl;

        // Reset state
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        step(2);
        chk_reset_vals("rst");

        // Power-up with constant lock: release, then count edges E1.. from release
        rst_n = 1'b1;
        step(3);
        chk("pu_pllrst_e3", pll_reset, 1);
        step(1);
        chk("pu_pllrst_e4", pll_reset, 0);
        chk("pu_state_e4", state, 1);
        step(1);
        chk("pu_state_e5", state, 2);
        step(7);
        chk("pu_state_e12", state, 2);
        chk("pu_enclk_e12", enclk, 0);
        step(1);
        chk("pu_state_e13", state, 3);
        chk("pu_enclk_t0", enclk, 3'b001);
        chk("pu_dom_t0", dom_rst_n, 3'b000);
        step(3);
        chk("pu_enclk_t3", enclk, 3'b001);
        step(1);
        chk("pu_enclk_t4", enclk, 3'b011);
        chk("pu_dom_t4", dom_rst_n, 3'b001);
        step(4);
        chk("pu_enclk_t8", enclk, 3'b111);
        chk("pu_dom_t8", dom_rst_n, 3'b011);
        step(3);
        chk("pu_ready_t11", all_ready, 0);
        chk("pu_state_t11", state, 3);
        step(1);
        chk("pu_dom_t12", dom_rst_n, 3'b111);
        chk("pu_ready_t12", all_ready, 1);
        chk("pu_state_t12", state, 4);
        chk("pu_relock", relock_cnt, 0);

        // One-cycle lock drop in RUN
        step(2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        chk("drop_ready_d2", all_ready, 1);
        step(1);
        chk("drop_ready_d3", all_ready, 0);
        chk("drop_enclk_d3", enclk, 0);
        chk("drop_dom_d3", dom_rst_n, 0);
        chk("drop_state_d3", state, 1);
        chk("drop_relock_d3", relock_cnt, 1);
        step(1);
        chk("drop_state_d4", state, 2);
        step(7);
        chk("drop_state_d11", state, 2);
        step(1);
        chk("drop_state_d12", state, 3);
        chk("drop_enclk_d12", enclk, 3'b001);
        wait_state("drop_run", 3'd4, 20);
        chk("drop_run_enclk", enclk, 3'b111);
        chk("drop_run_dom", dom_rst_n, 3'b111);
        chk("drop_run_ready", all_ready, 1);

        // Asynchronous reset mid-ENABLE
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        k = 0;
        while (enclk !== 3'b011 && k < 40) begin
            step(1);
            k++;
        end
        chk("async_pre_enclk", enclk, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        step(2);

        // Lock glitch after 5 lock-high cycles in STABLE
        rst_n = 1'b1;
        step(5);
        chk("glitch_state_e5", state, 2);
        step(3);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        chk("glitch_state_e11", state, 1);
        step(1);
        chk("glitch_state_e12", state, 2);
        step(7);
        chk("glitch_state_e19", state, 2);
        chk("glitch_enclk_e19", enclk, 0);
        step(1);
        chk("glitch_state_e20", state, 3);
        chk("glitch_enclk_e20", enclk, 3'b001);
        chk("glitch_relock", relock_cnt, 0);

        // Lock never arrives
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("nolock_state_e4", state, 1);
        chk("nolock_pllrst_e4", pll_reset, 0);
`ifdef PLL_CLK_SEQ_RELOCK_EN
        step(31);
        chk("to_state_e35", state, 1);
        chk("to_pllrst_e35", pll_reset, 0);
        step(1);
        chk("to_state_e36", state, 0);
        chk("to_pllrst_e36", pll_reset, 1);
        chk("to_relock_e36", relock_cnt, 1);
        step(3);
        chk("to_pllrst_e39", pll_reset, 1);
        step(1);
        chk("to_pllrst_e40", pll_reset, 0);
        chk("to_state_e40", state, 1);
        step(32);
        chk("to_pllrst_e72", pll_reset, 1);
        chk("to_relock_e72", relock_cnt, 2);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (pll_reset !== 1'b0)
                seen++;
        end
        chk("wait_no_repulse", seen, 0);
        chk("wait_state", state, 1);
        chk("wait_relock", relock_cnt, 0);
`endif

        // relock_cnt saturation through repeated loss in ENABLE
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        step(2);
        rst_n = 1'b1;
        for (int ev = 1; ev <= 257; ev++) begin
            wait_state("sat_enable", 3'd3, 40);
            pll_lock = 1'b0;
            step(3);
            exp_rl = (ev < 255) ? ev : 255;
            chk("sat_relock", relock_cnt, exp_rl);
            pll_lock = 1'b1;
        end
        chk("sat_enclk", enclk, 0);
        chk("sat_state", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_clk_seq.md
PLL_CLK_SEQ -- requirements
Module: pll_clk_seq

Interface
REQ-001 SHALL provide parameter NCH, default 7; number of sequenced output-clock channels, legal range 1..7.
REQ-002 SHALL provide parameter LOCK_CNT, default 1024; consecutive synchronised lock-high cycles required before sequencing starts.
REQ-003 SHALL provide parameter SEQ_GAP, default 16; cycles between successive sequencing events, minimum 1.
REQ-004 SHALL provide parameter PLL_RST_CYC, default 64; pll_reset pulse length in cycles.
REQ-005 SHALL provide parameter LOCK_TIMEOUT, default 65536; maximum cycles spent in WAIT_LOCK before the PLL is re-reset.
REQ-006 SHALL provide port clkin, input, 1; free-running reference clock and the only clock.
REQ-007 SHALL provide port rst_n, input, 1; asynchronous active-low reset.
REQ-008 SHALL provide port pll_lock, input, 1; raw PLL lock, asynchronous to clkin.
REQ-009 SHALL provide port pll_reset, output, 1; active-high PLL reset.
REQ-010 SHALL provide port enclk, output, NCH; per-channel PLL output enables, driving ENCLK0..ENCLKn.
REQ-011 SHALL provide port dom_rst_n, output, NCH; per-domain active-low resets.
REQ-012 SHALL provide port all_ready, output, 1; high only in state RUN.
REQ-013 SHALL provide port state, output, 3; encoded FSM state: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, ENABLE=3, RUN=4.
REQ-014 SHALL provide port relock_cnt, output, 8; count of lock-loss and timeout events, saturating at 255.

Function
REQ-015 SHALL synchronise pll_lock through two clkin flops; all decisions use the synchronised value lk, 2-cycle latency.
REQ-016 RESET_PLL SHALL hold pll_reset=1 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK with the cycle counter cleared; pll_reset=0 in every other state.
REQ-017 WAIT_LOCK SHALL go to STABLE on the first cycle with lk=1, counter cleared; timeout behaviour is per REQ-026/027.
REQ-018 STABLE SHALL count consecutive lk=1 cycles, go to ENABLE when the count reaches LOCK_CNT, and return to WAIT_LOCK with the counter cleared on any lk=0.
REQ-019 ENABLE SHALL assert enclk[i] at entry+i*SEQ_GAP cycles, where enclk[0] is set in the first ENABLE cycle.
REQ-020 ENABLE SHALL deassert dom_rst_n[i] SEQ_GAP cycles after enclk[i] rises.
REQ-021 ENABLE SHALL go to RUN in the cycle dom_rst_n[NCH-1] rises; all_ready rises in that same cycle.
REQ-022 lk=0 in ENABLE or RUN SHALL clear all enclk, dom_rst_n and all_ready on the next clkin edge, increment relock_cnt (saturating), and go to WAIT_LOCK.
REQ-023 Enables and resets once set SHALL stay set until lock loss or reset; no glitches; all outputs registered.
REQ-024 Counters SHALL be sized to hold the largest parameter value with no wrap-around; relock_cnt at 255 SHALL remain 255.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous), set state=RESET_PLL, pll_reset=1, enclk=0, dom_rst_n=0, all_ready=0, relock_cnt=0, sync flops=0 and counters=0; deassertion restarts a full PLL_RST_CYC pulse.

Configuration
REQ-026 With PLL_CLK_SEQ_RELOCK_EN defined, WAIT_LOCK reaching LOCK_TIMEOUT cycles without lk SHALL go to RESET_PLL and increment relock_cnt (saturating).
REQ-027 Without PLL_CLK_SEQ_RELOCK_EN, WAIT_LOCK SHALL wait indefinitely, never re-pulses pll_reset, and increments relock_cnt only per REQ-022.

Verification
Bench parameters: NCH=3, LOCK_CNT=8, SEQ_GAP=4, PLL_RST_CYC=4, LOCK_TIMEOUT=32.
REQ-028 Release rst_n, pll_lock=1 constantly -> pll_reset high 4 cycles, then STABLE; enclk bits rise 0/4/8 cycles after ENABLE entry; dom_rst_n bits rise at 4/8/12; all_ready=1 at 12; relock_cnt=0.
REQ-029 pll_lock toggles low after 5 high cycles in STABLE -> return to WAIT_LOCK, count restarts, no enclk asserted until 8 further consecutive high cycles.
REQ-030 In RUN, drop pll_lock for 1 cycle -> all outputs clear 3 cycles after the drop (2 sync + 1), relock_cnt=1, full re-sequence follows once lock returns.
REQ-031 pll_lock held 0 with macro defined -> pll_reset re-pulses every 4+32 cycles, relock_cnt increments each time; without macro -> single pulse, relock_cnt stays 0.
REQ-032 Assert rst_n mid-ENABLE (enclk=3'b011) -> all outputs reach reset values without a clkin edge; force relock_cnt to 255 with a further loss -> stays 255.
